// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package hazard_pkg;

  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic {
    RUN,
    LSTALL
  } state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle.
interface hazard_ctrl_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
);
  logic [NUM_SRC*REG_AW-1:0] Rs_D;
  logic [NUM_SRC-1:0]        UseD;
  logic [NUM_SRC*REG_AW-1:0] Rs_E;
  logic [REG_AW-1:0]         RD_E;
  logic [REG_AW-1:0]         RD_M;
  logic [REG_AW-1:0]         RD_W;
  logic                      RegWriteE;
  logic                      RegWriteM;
  logic                      RegWriteW;
  logic                      MemReadE;
  logic                      PCSrcE;
  logic                      StallF;
  logic                      StallD;
  logic                      FlushD;
  logic                      FlushE;
  logic [2*NUM_SRC-1:0]      ForwardE;
  logic [CNT_W-1:0]          stall_cnt;
  logic [CNT_W-1:0]          flush_cnt;

  modport master (
    output Rs_D, UseD, Rs_E, RD_E, RD_M, RD_W,
    output RegWriteE, RegWriteM, RegWriteW, MemReadE, PCSrcE,
    input  StallF, StallD, FlushD, FlushE, ForwardE, stall_cnt, flush_cnt
  );

  modport slave (
    input  Rs_D, UseD, Rs_E, RD_E, RD_M, RD_W,
    input  RegWriteE, RegWriteM, RegWriteW, MemReadE, PCSrcE,
    output StallF, StallD, FlushD, FlushE, ForwardE, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_fwd_sel.sv
// Forward-select for one E-stage source operand; MEM result beats WB result.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rd_m,
  input  logic [REG_AW-1:0] i_rd_w,
  input  logic              i_we_m,
  input  logic              i_we_w,
  output logic [1:0]        o_fwd
);
  logic w_hit_m;
  logic w_hit_w;

  assign w_hit_m = i_we_m && (i_rd_m != '0) && (i_rd_m == i_rs);
  assign w_hit_w = i_we_w && (i_rd_w != '0) && (i_rd_w == i_rs);

  assign o_fwd = w_hit_m ? FWD_MEM : (w_hit_w ? FWD_WB : FWD_NONE);
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: operand forwarding, load-use stall FSM, branch flush, event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);
  localparam logic [1:0] LAT_M1 = 2'(LOAD_LAT - 1);

  state_t               r_state;
  logic [1:0]           r_bub_cnt;
  logic [CNT_W-1:0]     r_stall_cnt;
  logic [CNT_W-1:0]     r_flush_cnt;
  logic [NUM_SRC-1:0]   w_use_match;
  logic [1:0]           w_fwd [NUM_SRC];
  logic [2*NUM_SRC-1:0] w_fwd_flat;
  logic                 w_hit;
  logic                 w_stall;
  logic                 w_flush;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    hazard_fwd_sel #(.REG_AW(REG_AW)) u_sel (
      .i_rs   (hz.Rs_E[g*REG_AW +: REG_AW]),
      .i_rd_m (hz.RD_M),
      .i_rd_w (hz.RD_W),
      .i_we_m (hz.RegWriteM),
      .i_we_w (hz.RegWriteW),
      .o_fwd  (w_fwd[g])
    );
  end

  always_comb begin
    w_fwd_flat  = '0;
    w_use_match = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_fwd_flat[2*i +: 2] = w_fwd[i];
      w_use_match[i] = hz.UseD[i] && (hz.Rs_D[i*REG_AW +: REG_AW] == hz.RD_E);
    end
  end

  assign w_hit   = hz.MemReadE && hz.RegWriteE && (hz.RD_E != '0) && (|w_use_match);
  // A taken branch squashes the dependent instruction, so it overrides any stall.
  assign w_flush = !rst && hz.PCSrcE;
  assign w_stall = !rst && !hz.PCSrcE && ((r_state == LSTALL) || w_hit);

  assign hz.StallF    = w_stall;
  assign hz.StallD    = w_stall;
  assign hz.FlushD    = w_flush;
  assign hz.FlushE    = w_flush || w_stall;
  assign hz.ForwardE  = rst ? '0 : w_fwd_flat;
  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_bub_cnt   <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_flush) r_flush_cnt <= sat_inc(r_flush_cnt);
      if (hz.PCSrcE) begin
        r_state   <= RUN;
        r_bub_cnt <= '0;
      end else begin
        case (r_state)
          RUN: begin
            // First bubble is issued from RUN; LSTALL covers the remaining LOAD_LAT-1.
            if (w_hit && (LOAD_LAT > 1)) begin
              r_state   <= LSTALL;
              r_bub_cnt <= LAT_M1;
            end
          end
          LSTALL: begin
            r_bub_cnt <= r_bub_cnt - 2'd1;
            if (r_bub_cnt == 2'd1) r_state <= RUN;
          end
          default: r_state <= RUN;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: three instances (LOAD_LAT=1, LOAD_LAT=3, CNT_W=4).
module tb_hazard_ctrl;
  typedef struct packed {
    logic [9:0] rs_d;
    logic [1:0] use_d;
    logic [9:0] rs_e;
    logic [4:0] rd_e;
    logic [4:0] rd_m;
    logic [4:0] rd_w;
    logic       we_e;
    logic       we_m;
    logic       we_w;
    logic       mr_e;
    logic       pcsrc;
  } in_t;

  typedef struct {
    int          dut;
    logic [39:0] v;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  in_t  drv [3];
  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(16)) ifa ();
  hazard_ctrl_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(16)) ifb ();
  hazard_ctrl_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(4))  ifc ();

  hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(16)) ua (.clk(clk), .rst(rst), .hz(ifa));
  hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(3), .CNT_W(16)) ub (.clk(clk), .rst(rst), .hz(ifb));
  hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(4))  uc (.clk(clk), .rst(rst), .hz(ifc));

  assign ifa.Rs_D = drv[0].rs_d;  assign ifa.UseD = drv[0].use_d;  assign ifa.Rs_E = drv[0].rs_e;
  assign ifa.RD_E = drv[0].rd_e;  assign ifa.RD_M = drv[0].rd_m;   assign ifa.RD_W = drv[0].rd_w;
  assign ifa.RegWriteE = drv[0].we_e;  assign ifa.RegWriteM = drv[0].we_m;  assign ifa.RegWriteW = drv[0].we_w;
  assign ifa.MemReadE = drv[0].mr_e;   assign ifa.PCSrcE = drv[0].pcsrc;

  assign ifb.Rs_D = drv[1].rs_d;  assign ifb.UseD = drv[1].use_d;  assign ifb.Rs_E = drv[1].rs_e;
  assign ifb.RD_E = drv[1].rd_e;  assign ifb.RD_M = drv[1].rd_m;   assign ifb.RD_W = drv[1].rd_w;
  assign ifb.RegWriteE = drv[1].we_e;  assign ifb.RegWriteM = drv[1].we_m;  assign ifb.RegWriteW = drv[1].we_w;
  assign ifb.MemReadE = drv[1].mr_e;   assign ifb.PCSrcE = drv[1].pcsrc;

  assign ifc.Rs_D = drv[2].rs_d;  assign ifc.UseD = drv[2].use_d;  assign ifc.Rs_E = drv[2].rs_e;
  assign ifc.RD_E = drv[2].rd_e;  assign ifc.RD_M = drv[2].rd_m;   assign ifc.RD_W = drv[2].rd_w;
  assign ifc.RegWriteE = drv[2].we_e;  assign ifc.RegWriteM = drv[2].we_m;  assign ifc.RegWriteW = drv[2].we_w;
  assign ifc.MemReadE = drv[2].mr_e;   assign ifc.PCSrcE = drv[2].pcsrc;

  // Expected vector layout: {StallF, StallD, FlushD, FlushE, ForwardE[3:0], stall_cnt[15:0], flush_cnt[15:0]}
  function automatic logic [39:0] mk(input logic sf, input logic sd, input logic fd, input logic fe,
                                     input logic [3:0] fwd, input int sc, input int fc);
    return {sf, sd, fd, fe, fwd, sc[15:0], fc[15:0]};
  endfunction

  function automatic in_t fwd_in(input logic [4:0] rd_m, input logic we_m, input logic [4:0] rd_w,
                                 input logic we_w, input logic [4:0] rs_e1, input logic [4:0] rs_e0);
    in_t v;
    v = '0;
    v.rd_m = rd_m;  v.we_m = we_m;
    v.rd_w = rd_w;  v.we_w = we_w;
    v.rs_e = {rs_e1, rs_e0};
    return v;
  endfunction

  function automatic in_t lu_in(input logic [4:0] rd_e, input logic [4:0] rs_d1, input logic [4:0] rs_d0,
                                input logic [1:0] use_d, input logic pc);
    in_t v;
    v = '0;
    v.mr_e = 1'b1;  v.we_e = 1'b1;  v.rd_e = rd_e;
    v.rs_d = {rs_d1, rs_d0};
    v.use_d = use_d;
    v.pcsrc = pc;
    return v;
  endfunction

  task automatic step(input int d, input in_t v, input logic r, input logic [39:0] e, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    drv[d] = v;
    rst    = r;
    x.dut  = d;
    x.v    = e;
    x.name = nm;
    q.push_back(x);
  endtask

  // Monitor: compares the oldest expectation against the addressed instance mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t        e;
      logic [39:0] act;
      e = q.pop_front();
      case (e.dut)
        0:       act = {ifa.StallF, ifa.StallD, ifa.FlushD, ifa.FlushE, ifa.ForwardE, ifa.stall_cnt, ifa.flush_cnt};
        1:       act = {ifb.StallF, ifb.StallD, ifb.FlushD, ifb.FlushE, ifb.ForwardE, ifb.stall_cnt, ifb.flush_cnt};
        default: act = {ifc.StallF, ifc.StallD, ifc.FlushD, ifc.FlushE, ifc.ForwardE,
                        12'd0, ifc.stall_cnt, 12'd0, ifc.flush_cnt};
      endcase
      total++;
      if (act !== e.v) begin
        bad++;
        $display("FAIL %s: got=%h want=%h", e.name, act, e.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t idle;
    in_t both;
    idle = '0;
    for (int i = 0; i < 3; i++) drv[i] = '0;

    // Reset: forwarding and load-use inputs present, everything must read zero.
    both = lu_in(5'd7, 5'd7, 5'd3, 2'b10, 1'b0);
    both.rd_m = 5'd5;  both.we_m = 1'b1;  both.rs_e = {5'd0, 5'd5};
    step(0, both, 1'b1, mk(0,0,0,0, 4'b0000, 0, 0), "rst_out");
    step(0, idle, 1'b0, mk(0,0,0,0, 4'b0000, 0, 0), "post_rst");

    // Forwarding on instance A
    step(0, fwd_in(5'd5, 1, 5'd5, 1, 5'd0, 5'd5), 1'b0, mk(0,0,0,0, 4'b0010, 0, 0), "fwd_mem");
    step(0, fwd_in(5'd0, 1, 5'd5, 1, 5'd0, 5'd5), 1'b0, mk(0,0,0,0, 4'b0001, 0, 0), "fwd_wb");
    step(0, fwd_in(5'd9, 1, 5'd6, 1, 5'd9, 5'd6), 1'b0, mk(0,0,0,0, 4'b1001, 0, 0), "fwd_two_ops");
    step(0, fwd_in(5'd5, 0, 5'd5, 1, 5'd5, 5'd5), 1'b0, mk(0,0,0,0, 4'b0101, 0, 0), "fwd_m_disabled");
    step(0, fwd_in(5'd0, 1, 5'd0, 1, 5'd0, 5'd0), 1'b0, mk(0,0,0,0, 4'b0000, 0, 0), "fwd_x0");

    // Load-use on instance A (LOAD_LAT=1)
    step(0, lu_in(5'd7, 5'd7, 5'd3, 2'b10, 0), 1'b0, mk(1,1,0,1, 4'b0000, 0, 0), "lu_hit");
    step(0, idle,                              1'b0, mk(0,0,0,0, 4'b0000, 1, 0), "lu_done");
    step(0, lu_in(5'd7, 5'd7, 5'd3, 2'b01, 0), 1'b0, mk(0,0,0,0, 4'b0000, 1, 0), "lu_masked");
    step(0, lu_in(5'd0, 5'd0, 5'd0, 2'b11, 0), 1'b0, mk(0,0,0,0, 4'b0000, 1, 0), "lu_x0");
    step(0, lu_in(5'd7, 5'd7, 5'd3, 2'b10, 1), 1'b0, mk(0,0,1,1, 4'b0000, 1, 0), "br_over_lu");
    step(0, idle,                              1'b0, mk(0,0,0,0, 4'b0000, 1, 1), "br_cnt");

    // Instance B (LOAD_LAT=3): full stall, then branch in the second stall cycle
    step(1, lu_in(5'd7, 5'd7, 5'd3, 2'b10, 0), 1'b0, mk(1,1,0,1, 4'b0000, 0, 0), "l3_c1");
    step(1, idle, 1'b0, mk(1,1,0,1, 4'b0000, 1, 0), "l3_c2");
    step(1, idle, 1'b0, mk(1,1,0,1, 4'b0000, 2, 0), "l3_c3");
    step(1, idle, 1'b0, mk(0,0,0,0, 4'b0000, 3, 0), "l3_run");
    step(1, idle, 1'b0, mk(0,0,0,0, 4'b0000, 3, 0), "l3_run2");
    step(1, lu_in(5'd7, 5'd7, 5'd3, 2'b10, 0), 1'b0, mk(1,1,0,1, 4'b0000, 3, 0), "l3b_c1");
    begin
      in_t br;
      br = idle;
      br.pcsrc = 1'b1;
      step(1, br, 1'b0, mk(0,0,1,1, 4'b0000, 4, 0), "l3b_branch");
    end
    step(1, idle, 1'b0, mk(0,0,0,0, 4'b0000, 4, 1), "l3b_run");

    // Reset in the middle of an LSTALL
    step(1, lu_in(5'd7, 5'd7, 5'd3, 2'b10, 0), 1'b0, mk(1,1,0,1, 4'b0000, 4, 1), "l3r_c1");
    step(1, idle, 1'b0, mk(1,1,0,1, 4'b0000, 5, 1), "l3r_c2");
    step(1, fwd_in(5'd5, 1, 5'd0, 0, 5'd0, 5'd5), 1'b1, mk(0,0,0,0, 4'b0000, 0, 0), "l3r_rst");
    step(1, idle, 1'b0, mk(0,0,0,0, 4'b0000, 0, 0), "l3r_rel");
    step(1, idle, 1'b0, mk(0,0,0,0, 4'b0000, 0, 0), "l3r_rel2");

    // Instance C (CNT_W=4): 20 back-to-back hits saturate stall_cnt at 15
    for (int k = 1; k <= 20; k++)
      step(2, lu_in(5'd7, 5'd7, 5'd3, 2'b10, 0), 1'b0,
           mk(1,1,0,1, 4'b0000, (k - 1 > 15) ? 15 : k - 1, 0), "sat_hit");
    step(2, idle, 1'b0, mk(0,0,0,0, 4'b0000, 15, 0), "sat_hold");
    step(2, idle, 1'b0, mk(0,0,0,0, 4'b0000, 15, 0), "sat_hold2");

    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: got=%0d pending want=0", q.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage RISC-V core, sitting beside the datapath and driving the F/D/E pipeline-register enables and the E-stage operand muxes. Adds three things on top of plain M/W forwarding: load-use stall detection with configurable bubble count, taken-branch flushing, and saturating stall/flush event counters. Operand forwarding is generalised to NUM_SRC source registers per instruction.

## Interface
- REG_AW, 5, register address width
- NUM_SRC, 2, source operands per instruction (2 or 3)
- LOAD_LAT, 1, bubbles required after a load before a dependent instruction may enter E (1..3)
- CNT_W, 16, width of event counters
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- Rs_D  in  NUM_SRC*REG_AW  decode-stage source addresses, operand i at [i*REG_AW +: REG_AW]
- UseD  in  NUM_SRC  decode-stage operand-used mask
- Rs_E  in  NUM_SRC*REG_AW  execute-stage source addresses
- RD_E, RD_M, RD_W  in  REG_AW each  destination addresses per stage
- RegWriteE, RegWriteM, RegWriteW  in  1 each  write-enable per stage
- MemReadE  in  1  E-stage instruction is a load
- PCSrcE  in  1  branch/jump taken, resolved in E
- StallF, StallD  out  1  hold PC / IF-ID register
- FlushD, FlushE  out  1  clear IF-ID / ID-EX register
- ForwardE  out  NUM_SRC*2  per-operand select, operand i at [2*i +: 2]
- stall_cnt, flush_cnt  out  CNT_W  event counters

## Operation
- Forwarding, per operand i, combinational: MEM (2'b10) if RegWriteM & RD_M!=0 & RD_M==Rs_E[i]; else WB (2'b01) if RegWriteW & RD_W!=0 & RD_W==Rs_E[i]; else NONE (2'b00). M beats W.
- Load-use hit: MemReadE & RegWriteE & RD_E!=0 & any i with UseD[i] & Rs_D[i]==RD_E.
- FSM states RUN, LSTALL; down-counter bub_cnt (2 bits).
- RUN: on hit (no PCSrcE) assert StallF, StallD, FlushE; if LOAD_LAT>1 load bub_cnt=LOAD_LAT-1 and go LSTALL, else stay RUN.
- LSTALL: assert StallF, StallD, FlushE; decrement bub_cnt; when bub_cnt==1 return to RUN next cycle.
- PCSrcE=1 in any state: FlushD=FlushE=1, StallF=StallD=0, bub_cnt cleared, next state RUN. Branch flush has priority over load stall.
- stall_cnt increments every cycle StallD=1; flush_cnt increments every cycle PCSrcE=1; both saturate at all-ones, never wrap.
- UseD[i]=0 masks operand i from load-use detection only; forwarding is not masked.

## Timing
- Forward selects, stall and flush outputs are combinational from current inputs and state, valid in the same cycle.
- Stall length for one load-use hit: exactly LOAD_LAT consecutive cycles of StallD=1.
- Counters update on the clock edge after the event; visible one cycle later.
- Reset (async assert, sync to clk on release): state RUN, bub_cnt=0, counters 0. While rst=1: ForwardE all 2'b00, StallF=StallD=FlushD=FlushE=0.
- Reset asserted during LSTALL aborts the stall immediately; no residual bubbles after release.
- x0 destination never causes forwarding or stall.

## Structure
- Package hazard_pkg: FWD_NONE/FWD_WB/FWD_MEM constants, state enum (RUN, LSTALL), default REG_AW.
- Sub-module hazard_fwd_sel: one operand's comparator/priority logic, instantiated NUM_SRC times via generate.
- FSM, bub_cnt and counters stay in hazard_ctrl.

## Test plan
- RD_M=5, RegWriteM=1, RD_W=5, RegWriteW=1, Rs_E[0]=5 -> ForwardE[1:0]=2'b10; with RD_M=0 instead -> 2'b01.
- LOAD_LAT=1: MemReadE=1, RD_E=7, Rs_D[1]=7, UseD=2'b10 -> StallD/FlushE high 1 cycle, stall_cnt=1; UseD=2'b01 -> no stall.
- LOAD_LAT=3: same hit -> StallD high exactly 3 cycles, then RUN; stall_cnt=3.
- LOAD_LAT=3, PCSrcE=1 in 2nd stall cycle -> FlushD=FlushE=1, StallD=0 that cycle, RUN next, flush_cnt=1.
- rst pulsed mid-LSTALL -> all outputs 0 immediately, counters 0, no stall after release.
- CNT_W=4, 20 consecutive load-use hits -> stall_cnt holds at 4'hF.
